// File: rtl/fp_norm_if.sv
// Start/busy/done handshake and payload bundle for the mantissa normalizer.
//   master: requester (drives start, mant_in, exp_in; observes status/results)
//   slave : normalizer (observes request; drives busy, done, results, flags)
//   start      request, sampled by the normalizer only while busy=0
//   mant_in    {carry, hidden, fraction} raw mantissa
//   exp_in     biased exponent of mant_in
//   busy/done  operation in progress / one-cycle result-valid pulse
//   mant_out   normalized fraction, hidden bit dropped
//   exp_out    biased result exponent
//   zero/overflow/underflow  result classification flags
interface fp_norm_if #(
  parameter int unsigned MANT_BITS = 23,
  parameter int unsigned EXP_BITS  = 8
);
  logic                 start;
  logic [MANT_BITS+1:0] mant_in;
  logic [EXP_BITS-1:0]  exp_in;
  logic                 busy;
  logic                 done;
  logic [MANT_BITS-1:0] mant_out;
  logic [EXP_BITS-1:0]  exp_out;
  logic                 zero;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output start, mant_in, exp_in,
    input  busy, done, mant_out, exp_out, zero, overflow, underflow
  );

  modport slave (
    input  start, mant_in, exp_in,
    output busy, done, mant_out, exp_out, zero, overflow, underflow
  );
endinterface

// File: rtl/fp_mantissa_normalizer.sv
// Sequential FP mantissa normalizer: takes a raw adder/subtractor mantissa
// (carry + hidden + fraction) with its biased exponent and normalizes it one
// bit position per cycle, producing the stored fraction and exponent plus
// zero/overflow/underflow classification.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any operation in flight)
//   bus    fp_norm_if.slave: start/mant_in/exp_in in, busy/done/results out
module fp_mantissa_normalizer #(
  parameter int unsigned MANT_BITS = 23,
  parameter int unsigned EXP_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  fp_norm_if.slave   bus
);

  localparam int unsigned MW      = MANT_BITS + 2;
  localparam int unsigned EW      = EXP_BITS + 1;
  localparam int unsigned EXP_MAX = (1 << EXP_BITS) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [MW-1:0] m;
  logic [EW-1:0] e;

  // Right-shift path for a carry-out; one extra exponent bit means no wrap.
  logic [MW-1:0] m_shr_c;
  logic [EW-1:0] e_inc_c;

  assign m_shr_c = m >> 1;
  assign e_inc_c = e + EW'(1);

  // FSM, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      m             <= '0;
      e             <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mant_out  <= '0;
      bus.exp_out   <= '0;
      bus.zero      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (bus.start) begin
            m <= bus.mant_in;
            // A zero biased exponent denotes a subnormal, whose true scale is E=1.
            e <= (bus.exp_in == '0) ? EW'(1) : EW'(bus.exp_in);
            bus.zero      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= NORM;
          end
        end

        NORM: begin
          if (m == '0) begin
            bus.zero     <= 1'b1;
            bus.mant_out <= '0;
            bus.exp_out  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            state        <= DONE;
          end else if (m[MW-1]) begin
            // Carry-out: truncating right shift, exponent up by one.
            m <= m_shr_c;
            e <= e_inc_c;
            if (e_inc_c >= EW'(EXP_MAX)) begin
              bus.overflow <= 1'b1;
              bus.mant_out <= '0;
              bus.exp_out  <= '1;
            end else begin
              bus.mant_out <= m_shr_c[MANT_BITS-1:0];
              bus.exp_out  <= e_inc_c[EXP_BITS-1:0];
            end
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else if (m[MANT_BITS]) begin
            bus.mant_out <= m[MANT_BITS-1:0];
            bus.exp_out  <= e[EXP_BITS-1:0];
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            state        <= DONE;
          end else if (e <= EW'(1)) begin
            // Cannot shift further without going below the minimum exponent.
            bus.underflow <= 1'b1;
            bus.mant_out  <= m[MANT_BITS-1:0];
            bus.exp_out   <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            state         <= DONE;
          end else begin
            m <= m << 1;
            e <= e - EW'(1);
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mantissa_normalizer.sv
// Directed self-checking bench for fp_mantissa_normalizer.
module tb_fp_mantissa_normalizer;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;
  int   cyc;
  int   done_seen;

  fp_norm_if #(.MANT_BITS(23), .EXP_BITS(8)) bus ();

  fp_mantissa_normalizer #(.MANT_BITS(23), .EXP_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge and count edges until done (bounded).
  // poke_cyc>0 re-asserts start with another vector while busy.
  task automatic issue(input logic [24:0] m, input logic [7:0] e,
                       input int poke_cyc, output int n);
    bus.mant_in = m;
    bus.exp_in  = e;
    bus.start   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n++;
      if (poke_cyc != 0 && n == poke_cyc) begin
        bus.mant_in = 25'h0800000;
        bus.exp_in  = 8'd5;
        bus.start   = 1'b1;
      end
    end while (!bus.done && n < 60);
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, bus.zero, bus.overflow, bus.underflow};
  endfunction

  initial begin
    checks = 0;
    fails = 0;
    bus.start = 1'b0;
    bus.mant_in = '0;
    bus.exp_in = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_mant", 32'(bus.mant_out), 32'd0);
    check("rst_exp", 32'(bus.exp_out), 32'd0);
    check("rst_flags", flags(), 32'd0);

    // T1: already normalized
    @(negedge clk);
    bus.mant_in = 25'h0800000;
    bus.exp_in  = 8'd127;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("t1_busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    check("t1_done", 32'(bus.done), 32'd1);
    check("t1_mant", 32'(bus.mant_out), 32'h0);
    check("t1_exp", 32'(bus.exp_out), 32'd127);
    check("t1_flags", flags(), 32'd0);
    @(posedge clk);
    #1;
    check("t1_done_pulse", 32'(bus.done), 32'd0);

    // T2: carry with truncated LSB
    issue(25'h1800001, 8'd130, 0, cyc);
    check("t2_lat", 32'(cyc), 32'd2);
    check("t2_mant", 32'(bus.mant_out), 32'h400000);
    check("t2_exp", 32'(bus.exp_out), 32'd131);
    check("t2_flags", flags(), 32'd0);

    // T3: maximum left shifts
    issue(25'h0000001, 8'd100, 0, cyc);
    check("t3_lat", 32'(cyc), 32'd25);
    check("t3_mant", 32'(bus.mant_out), 32'h0);
    check("t3_exp", 32'(bus.exp_out), 32'd77);
    check("t3_flags", flags(), 32'd0);

    // T4: underflow at E=1
    issue(25'h0000100, 8'd3, 0, cyc);
    check("t4_lat", 32'(cyc), 32'd4);
    check("t4_mant", 32'(bus.mant_out), 32'h400);
    check("t4_exp", 32'(bus.exp_out), 32'd0);
    check("t4_flags", flags(), 32'd1);

    // T5a: overflow
    issue(25'h1000000, 8'd254, 0, cyc);
    check("t5o_lat", 32'(cyc), 32'd2);
    check("t5o_mant", 32'(bus.mant_out), 32'h0);
    check("t5o_exp", 32'(bus.exp_out), 32'hFF);
    check("t5o_flags", flags(), 32'd2);

    // T5b: zero
    issue(25'h0000000, 8'd77, 0, cyc);
    check("t5z_lat", 32'(cyc), 32'd2);
    check("t5z_mant", 32'(bus.mant_out), 32'h0);
    check("t5z_exp", 32'(bus.exp_out), 32'd0);
    check("t5z_flags", flags(), 32'd4);

    // Subnormal input exponent with carry: E starts at 1, ends at 2
    issue(25'h1000002, 8'd0, 0, cyc);
    check("sub_c_mant", 32'(bus.mant_out), 32'h000001);
    check("sub_c_exp", 32'(bus.exp_out), 32'd2);
    check("sub_c_flags", flags(), 32'd0);

    // Subnormal exponent with hidden bit set: result exponent 1
    issue(25'h0800005, 8'd0, 0, cyc);
    check("sub_h_mant", 32'(bus.mant_out), 32'h000005);
    check("sub_h_exp", 32'(bus.exp_out), 32'd1);

    // Start while busy is ignored
    issue(25'h0000001, 8'd100, 3, cyc);
    check("ign_lat", 32'(cyc), 32'd25);
    check("ign_exp", 32'(bus.exp_out), 32'd77);
    check("ign_mant", 32'(bus.mant_out), 32'h0);

    // Start in the DONE cycle: back-to-back operation
    issue(25'h1800001, 8'd130, 0, cyc);
    check("b2b_lat", 32'(cyc), 32'd2);
    check("b2b_mant", 32'(bus.mant_out), 32'h400000);
    check("b2b_exp", 32'(bus.exp_out), 32'd131);

    // T6: reset mid-NORM
    @(negedge clk);
    bus.mant_in = 25'h0000001;
    bus.exp_in  = 8'd100;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstm_busy", 32'(bus.busy), 32'd0);
    check("rstm_exp", 32'(bus.exp_out), 32'd0);
    check("rstm_mant", 32'(bus.mant_out), 32'd0);
    check("rstm_flags", flags(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    check("rstm_no_done", 32'(done_seen), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
